fpu_arbiter: RTL and testbench

- Shares one free-running `fpu` adder instance between N_REQ requesters.
- Round-robin arbitration; accepted operands are held on the FPU inputs long enough to guarantee at least one complete FPU pass regardless of the FPU's internal phase.
- The captured result and status are returned to the granted requester as a one-cycle response tagged with its id.
- Sits between requesting datapath blocks and the `fpu` instance at the same clock level.

---
 rtl/fpu_arb_pkg.sv | 16 +
 rtl/fpu_arbiter_rr_picker.sv | 35 +++
 rtl/fpu_arbiter.sv | 120 ++++++++++++
 tb/tb_fpu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU arbiter slice.
package fpu_arb_pkg;

  localparam int FPU_WORD_W         = 32;
  localparam int FPU_STATUS_W       = 4;
  localparam int FPU_PERIOD_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    HOLD,
    CAPTURE,
    RESPOND
  } arb_state_t;

endpackage

// File: rtl/fpu_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan from the farthest position back to ptr so the nearest match is written last.
  always_comb begin
    grant   = '0;
    index   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos     = (int'(ptr) + k) % N;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        grant          = '0;
        grant[pos_idx] = 1'b1;
        index          = pos_idx;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one free-running FPU between N_REQ requesters.
// Define FPU_ARB_STATS_EN to add the ops_count / inexact_count statistics outputs.
import fpu_arb_pkg::*;

module fpu_arbiter #(
  parameter int N_REQ       = 4,
  parameter int FPU_PERIOD  = FPU_PERIOD_DEFAULT,
  parameter int HOLD_CYCLES = 2 * FPU_PERIOD,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                      clock100KHz,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*32-1:0]       req_op_a,
  input  logic [N_REQ*32-1:0]       req_op_b,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [FPU_WORD_W-1:0]     resp_data,
  output logic [FPU_STATUS_W-1:0]   resp_status,
  output logic                      busy,
  output logic [FPU_WORD_W-1:0]     fpu_op_a,
  output logic [FPU_WORD_W-1:0]     fpu_op_b,
  input  logic [FPU_WORD_W-1:0]     fpu_data,
  input  logic [FPU_STATUS_W-1:0]   fpu_status
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0]               ops_count,
  output logic [15:0]               inexact_count
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] hold_cnt;

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx),
    .found (pick_found)
  );

  // Every output is registered, so each one appears the cycle after the state that decides it.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      hold_cnt    <= '0;
      req_ack     <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
      resp_status <= '0;
      busy        <= 1'b0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
`ifdef FPU_ARB_STATS_EN
      ops_count     <= '0;
      inexact_count <= '0;
`endif
    end else begin
      req_ack    <= '0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (|req_valid) state <= GRANT;
        end
        GRANT: begin
          if (pick_found) begin
            fpu_op_a <= req_op_a[int'(pick_idx) * FPU_WORD_W +: FPU_WORD_W];
            fpu_op_b <= req_op_b[int'(pick_idx) * FPU_WORD_W +: FPU_WORD_W];
            cur_id   <= pick_idx;
            req_ack  <= pick_grant;
            busy     <= 1'b1;
            hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
            state    <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= CAPTURE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        CAPTURE: begin
          resp_data   <= fpu_data;
          resp_status <= fpu_status;
          state       <= RESPOND;
        end
        RESPOND: begin
          resp_valid <= 1'b1;
          resp_id    <= cur_id;
          rr_ptr     <= (int'(cur_id) == N_REQ - 1) ? '0 : cur_id + 1'b1;
`ifdef FPU_ARB_STATS_EN
          if (ops_count != 16'hFFFF) ops_count <= ops_count + 1'b1;
          if (resp_status != '0 && inexact_count != 16'hFFFF)
            inexact_count <= inexact_count + 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a behavioural free-running FPU stand-in (result = a + b).
`timescale 1ns/1ps
module tb_fpu_arbiter;
  import fpu_arb_pkg::*;

  localparam int N          = 4;
  localparam int HOLD_C     = 2 * FPU_PERIOD_DEFAULT;
  localparam int LAT        = HOLD_C + 2;
  localparam int OP_PERIOD  = HOLD_C + 4;

  logic              clock100KHz = 1'b0;
  logic              reset       = 1'b1;
  logic [N-1:0]      req_valid   = '0;
  logic [N*32-1:0]   req_op_a    = '0;
  logic [N*32-1:0]   req_op_b    = '0;
  logic [N-1:0]      req_ack;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [31:0]       resp_data;
  logic [3:0]        resp_status;
  logic              busy;
  logic [31:0]       fpu_op_a;
  logic [31:0]       fpu_op_b;
  logic [31:0]       fpu_data    = '0;
  logic [3:0]        fpu_status  = '0;
`ifdef FPU_ARB_STATS_EN
  logic [15:0]       ops_count;
  logic [15:0]       inexact_count;
`endif

  fpu_arbiter #(.N_REQ(N)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op_a    (req_op_a),
    .req_op_b    (req_op_b),
    .req_ack     (req_ack),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_status (resp_status),
    .busy        (busy),
    .fpu_op_a    (fpu_op_a),
    .fpu_op_b    (fpu_op_b),
    .fpu_data    (fpu_data),
    .fpu_status  (fpu_status)
`ifdef FPU_ARB_STATS_EN
    ,
    .ops_count     (ops_count),
    .inexact_count (inexact_count)
`endif
  );

  always #5 clock100KHz = ~clock100KHz;

  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [3:0] model_stat(input logic [31:0] a, input logic [31:0] b);
    return (a[0] | b[0]) ? 4'h1 : 4'h0;
  endfunction

  // FPU stand-in: samples operands at phase 0 and publishes the result at the end of the pass.
  int          phase = 2;
  logic [31:0] lat_a = '0, lat_b = '0;
  always @(posedge clock100KHz) begin
    phase <= (phase == FPU_PERIOD_DEFAULT - 1) ? 0 : phase + 1;
    if (phase == 0) begin
      lat_a <= fpu_op_a;
      lat_b <= fpu_op_b;
    end
    if (phase == FPU_PERIOD_DEFAULT - 1) begin
      fpu_data   <= model_sum(lat_a, lat_b);
      fpu_status <= model_stat(lat_a, lat_b);
    end
  end

  int cyc = 0;
  always @(posedge clock100KHz) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] data; logic [3:0] status; } exp_t;
  typedef struct { int id; logic [31:0] data; logic [3:0] status; int cyc; logic busy; } resp_t;

  exp_t         sb[$];
  resp_t        resp_log[$];
  int           ack_id[$];
  logic [N-1:0] ack_vec[$];
  int           ack_cyc[$];
  logic [N-1:0] keep_mask = '0;
  int           total = 0;
  int           bad = 0;

  task automatic clear_logs();
    sb.delete(); resp_log.delete(); ack_id.delete(); ack_vec.delete(); ack_cyc.delete();
  endtask

  // One cycle of requester behaviour: log acks/responses and drop acked requests.
  task automatic tick();
    resp_t r;
    @(negedge clock100KHz);
    if (req_ack != '0) begin
      ack_vec.push_back(req_ack);
      ack_cyc.push_back(cyc);
      for (int i = 0; i < N; i++) if (req_ack[i]) ack_id.push_back(i);
      req_valid = req_valid & ~(req_ack & ~keep_mask);
    end
    if (resp_valid) begin
      r.id = int'(resp_id); r.data = resp_data; r.status = resp_status;
      r.cyc = cyc; r.busy = busy;
      resp_log.push_back(r);
    end
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    req_op_a[id*32 +: 32] = a;
    req_op_b[id*32 +: 32] = b;
    req_valid[id] = 1'b1;
    e.id = id; e.data = model_sum(a, b); e.status = model_stat(a, b);
    sb.push_back(e);
  endtask

  task automatic wait_resps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (resp_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clock100KHz);
    reset = 1'b0;
    req_valid = '0; keep_mask = '0;
    #1;
    clear_logs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock100KHz);
    reset = 1'b0;
    #1;
    total++;
    if (req_ack !== '0 || resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== '0) begin
      bad++; $display("[TB] FAIL reset_ctrl: ack=%b rv=%b busy=%b id=%0d want all 0", req_ack, resp_valid, busy, resp_id);
    end
    total++;
    if (fpu_op_a !== '0 || fpu_op_b !== '0 || resp_data !== '0 || resp_status !== '0) begin
      bad++; $display("[TB] FAIL reset_data: opa=%h opb=%h data=%h st=%h want all 0", fpu_op_a, fpu_op_b, resp_data, resp_status);
    end
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_single();
    bit ok; exp_t e; resp_t r;
    issue(2, 32'h3E000000, 32'h3E000000);
    wait_resps(1, 60, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_timeout: got %0d resps want 1", resp_log.size()); return; end
    e = sb.pop_front(); r = resp_log.pop_front();
    total++;
    if (ack_vec.size() != 1 || ack_vec[0] !== 4'b0100) begin
      bad++; $display("[TB] FAIL single_ack: got %b (n=%0d) want 0100", ack_vec.size() > 0 ? ack_vec[0] : 4'bx, ack_vec.size());
    end
    total++;
    if (ack_cyc.size() < 1 || r.cyc - ack_cyc[0] != LAT) begin
      bad++; $display("[TB] FAIL single_latency: got %0d want %0d", ack_cyc.size() > 0 ? r.cyc - ack_cyc[0] : -1, LAT);
    end
    total++;
    if (r.id != e.id || r.data !== e.data || r.status !== e.status) begin
      bad++; $display("[TB] FAIL single_resp: got id=%0d data=%h st=%h want id=%0d data=%h st=%h", r.id, r.data, r.status, e.id, e.data, e.status);
    end
    total++;
    if (r.busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_resp: got %b want 1", r.busy); end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after: got %b want 0", busy); end
    clear_logs();
  endtask

  task automatic test_simultaneous();
    bit ok; exp_t e; resp_t r;
    do_reset();
    @(negedge clock100KHz);
    for (int k = 0; k < N; k++) issue(k, 32'h10000000 * (k + 1) + k, 32'h00001000 * (k + 1));
    wait_resps(N, 4 * OP_PERIOD + 20, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL sim_timeout: got %0d resps want %0d", resp_log.size(), N); end
    for (int k = 0; k < N && k < ack_id.size(); k++) begin
      total++;
      if (ack_id[k] != k) begin bad++; $display("[TB] FAIL sim_order%0d: got %0d want %0d", k, ack_id[k], k); end
    end
    for (int k = 1; k < ack_cyc.size(); k++) begin
      total++;
      if (ack_cyc[k] - ack_cyc[k-1] != OP_PERIOD) begin
        bad++; $display("[TB] FAIL sim_spacing%0d: got %0d want %0d", k, ack_cyc[k] - ack_cyc[k-1], OP_PERIOD);
      end
    end
    while (resp_log.size() > 0 && sb.size() > 0) begin
      e = sb.pop_front(); r = resp_log.pop_front();
      total++;
      if (r.id != e.id || r.data !== e.data || r.status !== e.status) begin
        bad++; $display("[TB] FAIL sim_resp: got id=%0d data=%h st=%h want id=%0d data=%h st=%h", r.id, r.data, r.status, e.id, e.data, e.status);
      end
    end
    clear_logs();
  endtask

  task automatic test_fairness();
    exp_t e; resp_t r; bit ok;
    ok = 1'b0;
    keep_mask = 4'b0011;
    @(negedge clock100KHz);
    issue(0, 32'h00000100, 32'h00000200);
    issue(1, 32'h00000301, 32'h00000400);
    for (int k = 2; k < 10; k++) begin
      e.id = k % 2;
      e.data = (k % 2 == 0) ? 32'h00000300 : 32'h00000701;
      e.status = (k % 2 == 0) ? 4'h0 : 4'h1;
      sb.push_back(e);
    end
    for (int k = 0; k < 10 * OP_PERIOD + 20; k++) begin
      tick();
      if (resp_log.size() >= 10) begin req_valid = '0; keep_mask = '0; ok = 1'b1; break; end
    end
    req_valid = '0; keep_mask = '0;
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL fair_timeout: got %0d resps want 10", resp_log.size()); end
    for (int k = 0; k < ack_id.size() && k < 10; k++) begin
      total++;
      if (ack_id[k] != k % 2) begin bad++; $display("[TB] FAIL fair_grant%0d: got %0d want %0d", k, ack_id[k], k % 2); end
    end
    while (resp_log.size() > 0 && sb.size() > 0) begin
      e = sb.pop_front(); r = resp_log.pop_front();
      total++;
      if (r.id != e.id || r.data !== e.data || r.status !== e.status) begin
        bad++; $display("[TB] FAIL fair_resp: got id=%0d data=%h st=%h want id=%0d data=%h st=%h", r.id, r.data, r.status, e.id, e.data, e.status);
      end
    end
    tick(); tick();
    clear_logs();
  endtask

  task automatic test_midreset();
    bit ok; exp_t e; resp_t r;
    @(negedge clock100KHz);
    issue(1, 32'h00005000, 32'h00000050);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin tick(); ok = (ack_id.size() > 0); end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL midrst_ack_timeout: got no ack want ack for 1"); end
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    total++;
    if (req_ack !== '0 || resp_valid !== 1'b0 || busy !== 1'b0 || fpu_op_a !== '0 || fpu_op_b !== '0 || resp_data !== '0) begin
      bad++; $display("[TB] FAIL midrst_outputs: ack=%b rv=%b busy=%b opa=%h opb=%h data=%h want all 0", req_ack, resp_valid, busy, fpu_op_a, fpu_op_b, resp_data);
    end
    clear_logs();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    total++;
    if (resp_log.size() != 0) begin bad++; $display("[TB] FAIL midrst_no_resp: got %0d resps want 0", resp_log.size()); end
    clear_logs();
    issue(3, 32'h00012345, 32'h00000011);
    wait_resps(1, 60, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL midrst_after_timeout: got 0 resps want 1"); return; end
    e = sb.pop_front(); r = resp_log.pop_front();
    total++;
    if (ack_id.size() < 1 || ack_id[0] != 3 || r.id != e.id || r.data !== e.data || r.status !== e.status) begin
      bad++; $display("[TB] FAIL midrst_after: got id=%0d data=%h st=%h want id=%0d data=%h st=%h", r.id, r.data, r.status, e.id, e.data, e.status);
    end
    clear_logs();
  endtask

  task automatic test_operand_stability();
    bit ok, stable; exp_t e; resp_t r;
    @(negedge clock100KHz);
    issue(0, 32'h11111110, 32'h01010100);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin tick(); ok = (ack_id.size() > 0); end
    tick();
    req_op_a[0 +: 32] = 32'hDEADBEEF;
    req_op_b[0 +: 32] = 32'h0BADF00D;
    stable = 1'b1;
    for (int k = 0; k < 40 && resp_log.size() == 0; k++) begin
      tick();
      if (resp_log.size() == 0 && (fpu_op_a !== 32'h11111110 || fpu_op_b !== 32'h01010100)) stable = 1'b0;
    end
    total++;
    if (!ok || resp_log.size() == 0) begin bad++; $display("[TB] FAIL stab_timeout: acks=%0d resps=%0d want 1/1", ack_id.size(), resp_log.size()); return; end
    total++;
    if (!stable) begin bad++; $display("[TB] FAIL stab_fpu_op: got opa=%h want 11111110", fpu_op_a); end
    e = sb.pop_front(); r = resp_log.pop_front();
    total++;
    if (r.data !== e.data || r.status !== e.status) begin
      bad++; $display("[TB] FAIL stab_resp: got data=%h st=%h want data=%h st=%h", r.data, r.status, e.data, e.status);
    end
    clear_logs();
  endtask

`ifdef FPU_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock100KHz);
      issue(k, 32'h00000100 + (k == 1 ? 1 : 0), 32'h00000010);
      resp_log.delete();
      wait_resps(1, 60, ok);
      total++;
      if (!ok) begin bad++; $display("[TB] FAIL stats_timeout%0d: got no resp want 1", k); end
    end
    tick();
    total++;
    if (ops_count !== 16'd3 || inexact_count !== 16'd1) begin
      bad++; $display("[TB] FAIL stats_counts: got ops=%0d inexact=%0d want 3/1", ops_count, inexact_count);
    end
    force dut.ops_count = 16'hFFFF;
    force dut.inexact_count = 16'hFFFF;
    #1;
    release dut.ops_count;
    release dut.inexact_count;
    clear_logs();
    @(negedge clock100KHz);
    issue(0, 32'h00000001, 32'h00000001);
    wait_resps(1, 60, ok);
    tick();
    total++;
    if (!ok || ops_count !== 16'hFFFF || inexact_count !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL stats_saturate: got ops=%h inexact=%h want FFFF/FFFF", ops_count, inexact_count);
    end
    clear_logs();
  endtask
`endif

  initial begin
    $display("[TB] starting fpu_arbiter bench");
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_midreset();
    test_operand_stability();
`ifdef FPU_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
